// File: rtl/noise_pkg.sv
// Shared constants for the PSG noise channel: LFSR geometry, reload seed,
// latch-byte codes and control-field positions.
package noise_pkg;

    localparam int          NOISE_LFSR_W = 15;
    localparam logic [14:0] NOISE_SEED   = 15'h4000;

    typedef enum logic [3:0] {
        NOISE_CTRL  = 4'b1110,
        NOISE_ATTEN = 4'b1111
    } latch_code_e;

    localparam int FB_POS = 2;
    localparam int NF_HI  = 1;
    localparam int NF_LO  = 0;

endpackage

// File: rtl/noise_lfsr.sv
// Noise shift register: reload on load, otherwise advance on shift using
// white (tap 0^1) or periodic (pure rotation) feedback.
module noise_lfsr
    import noise_pkg::*;
#(
    parameter int                LFSR_W = NOISE_LFSR_W,
    parameter logic [LFSR_W-1:0] SEED   = NOISE_SEED
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic shift,
    input  logic fb_mode,
    output logic noise_out
);

    logic [LFSR_W-1:0] lfsr_q;

    function automatic logic feedback_bit(input logic [LFSR_W-1:0] s, input logic white);
        return white ? (s[0] ^ s[1]) : s[0];
    endfunction

    // A reload always beats a coincident shift; the edge is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= SEED;
        end else if (shift) begin
            lfsr_q <= {feedback_bit(lfsr_q, fb_mode), lfsr_q[LFSR_W-1:1]};
        end
    end

    assign noise_out = lfsr_q[0];

endmodule

// File: rtl/noise_lfsr_gen.sv
// SN76489-style noise channel: decodes noise latch bytes, drives selecta and
// steps the LFSR on noise_clk rising edges. NOISE_ATTEN_EN adds noise_level.
module noise_lfsr_gen
    import noise_pkg::*;
#(
    parameter int                LFSR_W = NOISE_LFSR_W,
    parameter logic [LFSR_W-1:0] SEED   = NOISE_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       noise_clk,
    output logic [2:0] selecta,
`ifdef NOISE_ATTEN_EN
    output logic [3:0] noise_level,
`endif
    output logic       noise_out
);

    logic       nclk_q;
    logic       rise;
    logic       ctrl_wr;
    logic [2:0] selecta_q;

    assign ctrl_wr = wr_en && (wr_data[7:4] == NOISE_CTRL);
    assign rise    = noise_clk & ~nclk_q;

    // nclk_q tracks noise_clk even during a write so the edge is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            nclk_q    <= 1'b0;
            selecta_q <= 3'b000;
        end else begin
            nclk_q <= noise_clk;
            if (ctrl_wr) begin
                selecta_q <= wr_data[2:0];
            end
        end
    end

    assign selecta = selecta_q;

    noise_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (ctrl_wr),
        .shift     (rise),
        .fb_mode   (selecta_q[FB_POS]),
        .noise_out (noise_out)
    );

`ifdef NOISE_ATTEN_EN
    logic       atten_wr;
    logic [3:0] atten_q;
    logic [3:0] level_q;

    assign atten_wr = wr_en && (wr_data[7:4] == NOISE_ATTEN);

    // Attenuation F is silence, so the amplitude is the inverted attenuation.
    always_ff @(posedge clk) begin
        if (reset) begin
            atten_q <= 4'hF;
            level_q <= 4'h0;
        end else begin
            if (atten_wr) begin
                atten_q <= wr_data[3:0];
            end
            level_q <= noise_out ? ~atten_q : 4'h0;
        end
    end

    assign noise_level = level_q;
`else
    logic unused_wr_bit;
    assign unused_wr_bit = wr_data[3];
`endif

endmodule

// File: tb/tb_noise_lfsr_gen.sv
// Randomised and directed bench for noise_lfsr_gen against a behavioural
// model of the noise channel (define NOISE_ATTEN_EN to cover noise_level).
module tb_noise_lfsr_gen;

    localparam int          W    = 15;
    localparam logic [14:0] SEED = 15'h4000;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       noise_clk;
    logic [2:0] selecta;
    logic       noise_out;
`ifdef NOISE_ATTEN_EN
    logic [3:0] noise_level;
`endif

    int checks_passed = 0;
    int checks_total  = 0;

    // Behavioural model state
    int unsigned m_lfsr;
    int unsigned m_sel;
    int unsigned m_prev;
    int unsigned m_atten;
    int unsigned m_level;

    always #5 clk = ~clk;

    noise_lfsr_gen dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .noise_clk   (noise_clk),
        .selecta     (selecta),
`ifdef NOISE_ATTEN_EN
        .noise_level (noise_level),
`endif
        .noise_out   (noise_out)
    );

    function automatic int unsigned next_state(int unsigned s, int unsigned white);
        int unsigned fb;
        if (white != 0) fb = (s % 2) ^ ((s / 2) % 2);
        else            fb = s % 2;
        return (s / 2) + fb * 16384;
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        int unsigned nl;
        if (reset) begin
            m_lfsr = SEED; m_sel = 0; m_prev = 0; m_atten = 15; m_level = 0;
        end else begin
            nl = (m_lfsr % 2 == 1) ? (15 - m_atten) : 0;
            if (wr_en && wr_data[7:4] == 4'hE) begin
                m_sel  = wr_data[2:0];
                m_lfsr = SEED;
            end else if (noise_clk && m_prev == 0) begin
                m_lfsr = next_state(m_lfsr, m_sel / 4);
            end
`ifdef NOISE_ATTEN_EN
            if (wr_en && wr_data[7:4] == 4'hF) m_atten = wr_data[3:0];
`endif
            m_prev  = noise_clk;
            m_level = nl;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0; wr_data = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; noise_clk = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks_total++;
        if (selecta !== 3'b000) $display("FAIL reset_selecta: got %b want 000", selecta);
        else checks_passed++;
        checks_total++;
        if (noise_out !== 1'b0) $display("FAIL reset_noise_out: got %b want 0", noise_out);
        else checks_passed++;
        checks_total++;
        if (dut.u_lfsr.lfsr_q !== SEED) $display("FAIL reset_lfsr: got %h want %h", dut.u_lfsr.lfsr_q, SEED);
        else checks_passed++;
`ifdef NOISE_ATTEN_EN
        checks_total++;
        if (noise_level !== 4'h0) $display("FAIL reset_level: got %h want 0", noise_level);
        else checks_passed++;
`endif
    endtask

    task automatic test_periodic();
        int bad = 0;
        logic want;
        write_byte(8'hE0);
        for (int k = 1; k <= 30; k++) begin
            noise_clk = 1'b1; tick();
            want = (k == 14 || k == 29);
            if (noise_out !== want) begin
                bad++;
                $display("FAIL periodic_rise%0d: got %b want %b", k, noise_out, want);
            end
            noise_clk = 1'b0; tick();
        end
        checks_total++;
        if (bad != 0) $display("FAIL periodic_seq: %0d bad rises, want 0", bad);
        else checks_passed++;
        checks_total++;
        if (selecta !== 3'b000) $display("FAIL periodic_selecta: got %b want 000", selecta);
        else checks_passed++;
    endtask

    task automatic test_white();
        write_byte(8'hE4);
        for (int k = 1; k <= 15; k++) begin
            noise_clk = 1'b1; tick();
            if (k == 13) begin
                checks_total++;
                if (dut.u_lfsr.lfsr_q !== 15'h0002) $display("FAIL white_r13: got %h want 0002", dut.u_lfsr.lfsr_q);
                else checks_passed++;
            end else if (k == 14) begin
                checks_total++;
                if (dut.u_lfsr.lfsr_q !== 15'h4001 || noise_out !== 1'b1)
                    $display("FAIL white_r14: got %h/%b want 4001/1", dut.u_lfsr.lfsr_q, noise_out);
                else checks_passed++;
            end else if (k == 15) begin
                checks_total++;
                if (dut.u_lfsr.lfsr_q !== 15'h6000 || noise_out !== 1'b0)
                    $display("FAIL white_r15: got %h/%b want 6000/0", dut.u_lfsr.lfsr_q, noise_out);
                else checks_passed++;
            end
            noise_clk = 1'b0; tick();
        end
        checks_total++;
        if (selecta !== 3'b100) $display("FAIL white_selecta: got %b want 100", selecta);
        else checks_passed++;
    endtask

    task automatic test_held_clk();
        int unsigned snap, want;
        snap = dut.u_lfsr.lfsr_q;
        want = next_state(next_state(snap, selecta[2]), selecta[2]);
        noise_clk = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        noise_clk = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        noise_clk = 1'b1; tick();
        noise_clk = 1'b0; tick();
        checks_total++;
        if (dut.u_lfsr.lfsr_q !== want[14:0]) $display("FAIL held_clk: got %h want %h", dut.u_lfsr.lfsr_q, want[14:0]);
        else checks_passed++;
    endtask

    task automatic test_write_with_rise();
        for (int i = 0; i < 5; i++) begin
            noise_clk = 1'b1; tick(); noise_clk = 1'b0; tick();
        end
        noise_clk = 1'b1; wr_en = 1'b1; wr_data = 8'hE6;
        tick();
        wr_en = 1'b0; wr_data = 8'h00;
        checks_total++;
        if (dut.u_lfsr.lfsr_q !== SEED || selecta !== 3'b110)
            $display("FAIL write_rise: got %h/%b want 4000/110", dut.u_lfsr.lfsr_q, selecta);
        else checks_passed++;
        tick();
        checks_total++;
        if (dut.u_lfsr.lfsr_q !== SEED) $display("FAIL write_rise_consumed: got %h want 4000", dut.u_lfsr.lfsr_q);
        else checks_passed++;
        noise_clk = 1'b0; tick();
    endtask

    task automatic test_reset_priority();
        noise_clk = 1'b1; tick(); noise_clk = 1'b0; tick();
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'hE7; noise_clk = 1'b1;
        tick();
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; noise_clk = 1'b0;
        checks_total++;
        if (dut.u_lfsr.lfsr_q !== SEED || selecta !== 3'b000)
            $display("FAIL reset_priority: got %h/%b want 4000/000", dut.u_lfsr.lfsr_q, selecta);
        else checks_passed++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            noise_clk = ($urandom_range(0, 2) != 0);
            wr_en     = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 3))
                0:       wr_data = {4'hE, 4'($urandom_range(0, 15))};
                1:       wr_data = {4'hF, 4'($urandom_range(0, 15))};
                default: wr_data = 8'($urandom);
            endcase
            tick();
            if (dut.u_lfsr.lfsr_q !== m_lfsr[14:0] || selecta !== m_sel[2:0] || noise_out !== m_lfsr[0]) begin
                bad++;
                if (bad < 5)
                    $display("FAIL random_cycle%0d: got %h/%b/%b want %h/%b/%b", i,
                             dut.u_lfsr.lfsr_q, selecta, noise_out, m_lfsr[14:0], m_sel[2:0], m_lfsr[0]);
            end
`ifdef NOISE_ATTEN_EN
            if (noise_level !== m_level[3:0]) begin
                bad++;
                if (bad < 5) $display("FAIL random_level%0d: got %h want %h", i, noise_level, m_level[3:0]);
            end
`endif
        end
        wr_en = 1'b0; wr_data = 8'h00; noise_clk = 1'b0;
        tick();
        checks_total++;
        if (bad != 0) $display("FAIL random: %0d mismatching cycles, want 0", bad);
        else checks_passed++;
    endtask

`ifdef NOISE_ATTEN_EN
    task automatic test_atten();
        write_byte(8'hF5);
        write_byte(8'hE0);
        for (int k = 1; k <= 14; k++) begin
            noise_clk = 1'b1; tick(); noise_clk = 1'b0;
            if (k < 14) tick();
        end
        tick();
        checks_total++;
        if (noise_out !== 1'b1 || noise_level !== 4'hA)
            $display("FAIL atten_level: got %b/%h want 1/a", noise_out, noise_level);
        else checks_passed++;
        write_byte(8'hFF);
        tick();
        checks_total++;
        if (noise_out !== 1'b1 || noise_level !== 4'h0)
            $display("FAIL atten_silent: got %b/%h want 1/0", noise_out, noise_level);
        else checks_passed++;
    endtask
`endif

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; noise_clk = 1'b0;
        m_lfsr = SEED; m_sel = 0; m_prev = 0; m_atten = 15; m_level = 0;
        test_reset();
        test_periodic();
        test_white();
        test_held_clk();
        test_write_with_rise();
        test_reset_priority();
        test_random();
`ifdef NOISE_ATTEN_EN
        test_atten();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
